// File: rtl/button_events.sv
// Multi-channel push-button front end: synchronise, debounce and classify NUM_BTN active-low buttons.
// Optional long-press detection is compiled in when BTN_LONGPRESS_EN is defined.
module button_events #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] held,
    output logic               any_press
);

    localparam int             DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        DOWN     = 2'd2,
        DB_REL   = 2'd3
    } state_e;

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    state_e             state_q  [NUM_BTN];
    state_e             state_d  [NUM_BTN];
    logic [DBW-1:0]     db_cnt_q [NUM_BTN];
    logic [DBW-1:0]     db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] held_q, held_d;
    logic               any_press_q, any_press_d;

    // sync2_q is the synchronised "pressed" level (p_s) for each channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sync1_d   = ~btn;
        sync2_d   = sync1_q;
        press_d   = '0;
        release_d = '0;
        held_d    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i]  = state_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i]  = DB_PRESS;
                        db_cnt_d[i] = DBW'(1);
                    end
                end
                DB_PRESS: begin
                    if (!sync2_q[i]) begin
                        state_d[i]  = IDLE;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_MAX) begin
                        state_d[i]  = DOWN;
                        db_cnt_d[i] = '0;
                        press_d[i]  = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                    end
                end
                DOWN: begin
                    if (!sync2_q[i]) begin
                        state_d[i]  = DB_REL;
                        db_cnt_d[i] = DBW'(1);
                    end
                end
                DB_REL: begin
                    if (sync2_q[i]) begin
                        state_d[i]  = DOWN;
                        db_cnt_d[i] = '0;
                    end else if (db_cnt_q[i] == DB_MAX) begin
                        state_d[i]   = IDLE;
                        db_cnt_d[i]  = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                    end
                end
                default: begin
                    state_d[i]  = IDLE;
                    db_cnt_d[i] = '0;
                end
            endcase
            held_d[i] = (state_d[i] == DOWN) || (state_d[i] == DB_REL);
        end
        any_press_d = |press_d;
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            held_q      <= '0;
            any_press_q <= 1'b0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so they are reset like any register.
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]  <= IDLE;
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            press_q     <= press_d;
            release_q   <= release_d;
            held_q      <= held_d;
            any_press_q <= any_press_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i]  <= state_d[i];
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [HW-1:0]      hold_cnt_q [NUM_BTN];
    logic [HW-1:0]      hold_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] long_q, long_d;

    // The hold count is 0 on the press-pulse cycle, so reaching HOLD_MAX lands HOLD_CYCLES later.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            hold_cnt_d[i] = hold_cnt_q[i];
            if (press_d[i]) begin
                hold_cnt_d[i] = '0;
            end else if (((state_q[i] == DOWN) || (state_q[i] == DB_REL)) &&
                         (hold_cnt_q[i] != HOLD_MAX)) begin
                hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                long_d[i]     = (hold_cnt_d[i] == HOLD_MAX) && (state_d[i] != IDLE);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            long_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign long_pulse = long_q;
`else
    // Long-press disabled: HOLD_CYCLES has no effect and the expression below is constant 0.
    assign long_pulse = {NUM_BTN{HOLD_CYCLES < 0}};
`endif

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign held          = held_q;
    assign any_press     = any_press_q;

endmodule

// File: tb/tb_button_events.sv
// Directed self-checking bench for button_events (NUM_BTN=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20).
// Long-press expectations follow BTN_LONGPRESS_EN, matching the RTL build.
module tb_button_events;

    localparam int NB   = 4;
    localparam int DB   = 4;
    localparam int HOLD = 20;
    // Drive before edge 1: sampled at edge 1, synchronised by edge 2, debounced over edges 3..6, pulse after edge 7.
    localparam int LAT  = 7;

`ifdef BTN_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn   = '0;
    logic [NB-1:0] press_pulse, release_pulse, long_pulse, held;
    logic          any_press;
    logic [16:0]   observed;
    logic [16:0]   expected;

    int vectors     = 0;
    int miscompares = 0;

    button_events #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .held         (held),
        .any_press    (any_press)
    );

    always #5 clk = ~clk;

    assign observed = {press_pulse, release_pulse, long_pulse, held, any_press};

    function automatic logic [16:0] pack_exp(input logic [3:0] p, input logic [3:0] r,
                                             input logic [3:0] l, input logic [3:0] h);
        return {p, r, l, h, |p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 1; n <= 5; n++) begin
            step();
            vectors++;
            if (observed !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_hold n=%0d got %h exp %h", n, observed, 17'h0);
            end
        end
        reset = 1'b1;
        btn   = 4'b1111;
        for (int n = 1; n <= 10; n++) begin
            step();
            vectors++;
            if (observed !== 17'h0) begin
                miscompares++;
                $display("FAIL idle_after_reset n=%0d got %h exp %h", n, observed, 17'h0);
            end
        end
    endtask

    task automatic test_press_release();
        btn[0] = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 31) btn[0] = 1'b1;
            step();
            expected = pack_exp(4'(n == LAT), 4'(n == 31 + LAT - 1),
                                4'(LONG_EN && n == LAT + HOLD), 4'(n >= LAT && n < 31 + LAT - 1));
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL press_release n=%0d got %h exp %h", n, observed, expected);
            end
        end
    endtask

    task automatic test_bounce();
        for (int n = 1; n <= 38; n++) begin
            if (n <= 30) btn[1] = (((n - 1) % 6) >= 3);
            step();
            vectors++;
            if (observed !== 17'h0) begin
                miscompares++;
                $display("FAIL bounce n=%0d got %h exp %h", n, observed, 17'h0);
            end
        end
        btn[1] = 1'b1;
    endtask

    task automatic test_glitch();
        btn[2] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 10) btn[2] = 1'b1;
            if (n == 12) btn[2] = 1'b0;
            if (n == 20) btn[2] = 1'b1;
            step();
            expected = pack_exp(4'(n == LAT) << 2, 4'(n == 20 + LAT - 1) << 2,
                                4'b0, 4'(n >= LAT && n < 20 + LAT - 1) << 2);
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL glitch n=%0d got %h exp %h", n, observed, expected);
            end
        end
    endtask

    task automatic test_simultaneous();
        btn = 4'b0110;
        for (int n = 1; n <= 20; n++) begin
            if (n == 11) btn = 4'b1111;
            step();
            expected = pack_exp((n == LAT) ? 4'b1001 : 4'b0000,
                                (n == 11 + LAT - 1) ? 4'b1001 : 4'b0000, 4'b0,
                                (n >= LAT && n < 11 + LAT - 1) ? 4'b1001 : 4'b0000);
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL simultaneous n=%0d got %h exp %h", n, observed, expected);
            end
        end
    endtask

    task automatic test_long_press();
        btn[0] = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 51) btn[0] = 1'b1;
            step();
            expected = pack_exp(4'(n == LAT), 4'(n == 51 + LAT - 1),
                                4'(LONG_EN && n == LAT + HOLD), 4'(n >= LAT && n < 51 + LAT - 1));
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL long_press n=%0d got %h exp %h", n, observed, expected);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        btn[3] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            expected = pack_exp(4'(n == LAT) << 3, 4'b0, 4'b0, 4'(n >= LAT) << 3);
            vectors++;
            if (observed !== expected) begin
                miscompares++;
                $display("FAIL pre_reset_hold n=%0d got %h exp %h", n, observed, expected);
            end
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (observed !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_async got %h exp %h", observed, 17'h0);
        end
        btn = 4'b1111;
        for (int n = 1; n <= 3; n++) begin
            step();
            vectors++;
            if (observed !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_mid n=%0d got %h exp %h", n, observed, 17'h0);
            end
        end
        reset = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            vectors++;
            if (observed !== 17'h0) begin
                miscompares++;
                $display("FAIL no_release_after_reset n=%0d got %h exp %h", n, observed, 17'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_long_press();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
